vec_sqsum_ctrl: RTL and testbench

Sequencer that drives the shared vector ALU (sum-of-squares datapath, a² + b²) to compute the squared-sum over two vectors in memory: Σ(A[i]² + B[i]²) for i = 0..len-1. It fetches operand pairs over a single-port memory read handshake and presents them to the ALU one pair per step. It accumulates the ALU result and reports a 32-bit total with a one-cycle done pulse. It sits beside the core as a memory-mapped accelerator, and owns the ALU operand and enable inputs.

---
 rtl/vec_sqsum_ctrl.sv | 158 +++++++++++++++
 tb/tb_vec_sqsum_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sqsum_ctrl.sv
// Sequencer for the shared sum-of-squares vector ALU. Fetches A[i]/B[i] pairs over a
// single-port read handshake, presents them to the ALU and accumulates a 32-bit total
// with a sticky carry-out flag and a one-cycle done pulse.
module vec_sqsum_ctrl #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              ovf,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [31:0]       rd_data,
  output logic [31:0]       alu_op1,
  output logic [31:0]       alu_op2,
  output logic              alu_vec_en,
  output logic [3:0]        alu_type,
  input  logic [31:0]       alu_out
);

  typedef enum logic [2:0] {StIdle, StFetchA, StFetchB, StAcc, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d;
  logic [ADDR_W-1:0]   base_b_q, base_b_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [31:0]         result_q, result_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         op1_q, op1_d;
  logic [31:0]         op2_q, op2_d;
  logic                carry;

  // Byte offset of element i (word-sized elements); wraps with the address width.
  function automatic logic [ADDR_W-1:0] elem_off(input logic [LEN_W-1:0] i);
    return ADDR_W'({i, 2'b00});
  endfunction

  // Next-state, capture and accumulate logic.
  always_comb begin
    state_d  = state_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    idx_d    = idx_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    addr_d   = addr_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    carry    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          len_d    = len;
          idx_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          if (len == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFetchA;
            addr_d  = base_a;
          end
        end
      end
      StFetchA: begin
        // abort wins over a same-cycle ack; the read data is dropped
        if (abort) begin
          state_d = StIdle;
        end else if (rd_ack) begin
          op1_d   = rd_data;
          state_d = StFetchB;
          addr_d  = base_b_q + elem_off(idx_q);
        end
      end
      StFetchB: begin
        if (abort) begin
          state_d = StIdle;
        end else if (rd_ack) begin
          op2_d   = rd_data;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          {carry, result_d} = {1'b0, result_q} + {1'b0, alu_out};
          ovf_d = ovf_q | carry;
          idx_d = idx_q + LEN_W'(1);
          if (idx_d == len_q) begin
            state_d = StDone;
          end else begin
            state_d = StFetchA;
            addr_d  = base_a_q + elem_off(idx_d);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  // Status, handshake and ALU control decoded from the current state.
  always_comb begin
    busy       = (state_q == StFetchA) || (state_q == StFetchB) || (state_q == StAcc);
    done       = (state_q == StDone);
    rd_req     = (state_q == StFetchA) || (state_q == StFetchB);
    alu_vec_en = (state_q == StAcc);
    alu_type   = 4'h0;
    rd_addr    = addr_q;
    result     = result_q;
    ovf        = ovf_q;
    alu_op1    = op1_q;
    alu_op2    = op2_q;
  end

endmodule

// File: tb/tb_vec_sqsum_ctrl.sv
// Self-checking bench for vec_sqsum_ctrl: memory responder with per-request latency,
// a reference model of the squared-sum, addresses and done timing, and directed cases.
module tb_vec_sqsum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_a = '0;
  logic [31:0] base_b = '0;
  logic [7:0]  len = '0;
  logic        busy, done, ovf, rd_req, alu_vec_en;
  logic        rd_ack = 1'b0;
  logic [31:0] result, rd_addr, alu_op1, alu_op2, alu_out;
  logic [31:0] rd_data = '0;
  logic [3:0]  alu_type;

  vec_sqsum_ctrl #(.LEN_W(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b), .len(len),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_vec_en(alu_vec_en),
    .alu_type(alu_type), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // External ALU: a^2 + b^2, wrapping mod 2^32.
  assign alu_out = alu_op1 * alu_op1 + alu_op2 * alu_op2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] mem [logic [31:0]];
  logic [31:0] va [256];
  logic [31:0] vb [256];
  logic [31:0] exp_addr_q [$];
  logic [31:0] addr_log [$];
  int          lat_q [$];
  bit          arm = 0, active = 0, pend = 0;
  int          rel = 0, exp_done_rel = 0, exp_len = 0, vec_cnt = 0, ack_cnt = 0;
  int          done_rel_seen = 0, cur_lat = 0, wait_cnt = 0;
  logic [31:0] exp_result = '0, last_result = '0, pend_addr = '0;
  logic        exp_ovf = 1'b0, last_ovf = 1'b0;

  // Compare process and memory responder, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      active = 0; pend = 0; rd_ack = 1'b0;
      last_result = '0; last_ovf = 1'b0;
    end else begin
      if (arm) begin
        arm = 0; active = 1; rel = 1; vec_cnt = 0; ack_cnt = 0; wait_cnt = 0;
        addr_log.delete();
        cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      end else if (active) begin
        rel++;
      end
      check("alu_type", alu_type, 4'h0);
      if (active && abort) begin
        check("abort_rd_req", rd_req, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, exp_result);
        check("abort_ovf", ovf, exp_ovf);
        active = 0; pend = 0;
        last_result = exp_result; last_ovf = exp_ovf;
        exp_addr_q.delete(); lat_q.delete();
      end else if (active) begin
        check("done_timing", done, rel == exp_done_rel);
        check("busy", busy, rel < exp_done_rel);
        if (alu_vec_en) vec_cnt++;
        if (done) begin
          done_rel_seen = rel;
          check("result", result, exp_result);
          check("ovf", ovf, exp_ovf);
          check("vec_en_count", vec_cnt, exp_len);
        end
        if (done || rel >= exp_done_rel) begin
          active = 0;
          last_result = exp_result; last_ovf = exp_ovf;
        end
      end else begin
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rd_req", rd_req, 0);
        check("idle_vec_en", alu_vec_en, 0);
        check("idle_result_hold", result, last_result);
        check("idle_ovf_hold", ovf, last_ovf);
      end
      // Responder
      if (pend) begin
        check("rd_req_hold", rd_req, 1);
        check("rd_addr_hold", rd_addr, pend_addr);
      end
      rd_ack  = 1'b0;
      rd_data = $urandom;
      if (rd_req && active) begin
        if (wait_cnt >= cur_lat) begin
          rd_ack = 1'b1;
          if (exp_addr_q.size() == 0) check("rd_addr_extra", 1, 0);
          else check("rd_addr", rd_addr, exp_addr_q.pop_front());
          addr_log.push_back(rd_addr);
          rd_data  = mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF;
          ack_cnt++;
          wait_cnt = 0;
          cur_lat  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
          pend     = 0;
        end else begin
          wait_cnt++;
          pend = 1; pend_addr = rd_addr;
        end
      end else begin
        pend   = 0;
        rd_ack = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
      end
    end
  end

  // Builds expected addresses, latencies, total, carry flag and done cycle.
  task automatic prep_cmd(input logic [31:0] ba, input logic [31:0] bb, input int n,
                          input int lat);
    logic [31:0] acc, a, b, t;
    logic        c;
    int          lsum, l;
    for (int i = 0; i < n; i++) mem[ba + 32'(4 * i)] = va[i];
    for (int i = 0; i < n; i++) mem[bb + 32'(4 * i)] = vb[i];
    exp_addr_q.delete(); lat_q.delete();
    acc = '0; exp_ovf = 1'b0; lsum = 0;
    for (int i = 0; i < n; i++) begin
      a = mem[ba + 32'(4 * i)];
      b = mem[bb + 32'(4 * i)];
      exp_addr_q.push_back(ba + 32'(4 * i));
      exp_addr_q.push_back(bb + 32'(4 * i));
      t = a * a + b * b;
      {c, acc} = {1'b0, acc} + {1'b0, t};
      exp_ovf = exp_ovf | c;
    end
    for (int k = 0; k < 2 * n; k++) begin
      l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      lat_q.push_back(l);
      lsum += l;
    end
    exp_result   = acc;
    exp_len      = n;
    exp_done_rel = 1 + 3 * n + lsum;
  endtask

  task automatic launch(input logic [31:0] ba, input logic [31:0] bb, input int n);
    @(negedge clk);
    base_a = ba; base_b = bb; len = n[7:0]; start = 1'b1; arm = 1; done_rel_seen = -1;
    @(negedge clk);
    start = 1'b0; base_a = $urandom; base_b = $urandom; len = 8'($urandom);
  endtask

  task automatic wait_cmd(output int drel);
    for (int k = 0; k < 3000 && active; k++) @(negedge clk);
    if (active) begin
      check("cmd_timeout", 1, 0);
      active = 0;
    end
    drel = done_rel_seen;
  endtask

  task automatic run_cmd(input logic [31:0] ba, input logic [31:0] bb, input int n,
                         input int lat, output int drel);
    prep_cmd(ba, bb, n, lat);
    launch(ba, bb, n);
    wait_cmd(drel);
  endtask

  int          drel, n;
  bit          aborted;
  logic [31:0] ba, bb;
  logic [31:0] exp_seq [6];

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_result", result, 0);   check("rst_ovf", ovf, 0);
    check("rst_rd_req", rd_req, 0);   check("rst_rd_addr", rd_addr, 0);
    check("rst_op1", alu_op1, 0);     check("rst_op2", alu_op2, 0);
    check("rst_vec_en", alu_vec_en, 0);
    rst_n = 1'b1;

    // len=1, 3^2 + 4^2
    va[0] = 3; vb[0] = 4;
    run_cmd(32'h0, 32'h40, 1, 0, drel);
    check("t1_done_cycle", drel, 4); check("t1_result", result, 25);
    check("t1_ovf", ovf, 0);         check("t1_vec_en", vec_cnt, 1);

    // len=3 zero-wait: 1+16+4+25+9+36 = 91
    va[0] = 1; va[1] = 2; va[2] = 3; vb[0] = 4; vb[1] = 5; vb[2] = 6;
    run_cmd(32'h100, 32'h200, 3, 0, drel);
    check("t2_done_cycle", drel, 10); check("t2_result", result, 91);
    exp_seq[0] = 32'h100; exp_seq[1] = 32'h200; exp_seq[2] = 32'h104;
    exp_seq[3] = 32'h204; exp_seq[4] = 32'h108; exp_seq[5] = 32'h208;
    check("t2_addr_count", addr_log.size(), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) check("t2_addr_seq", addr_log[i], exp_seq[i]);

    // same vectors, two wait cycles per read
    run_cmd(32'h100, 32'h200, 3, 2, drel);
    check("t3_done_cycle", drel, 22); check("t3_result", result, 91);

    // len=0: immediate done, result cleared, no reads
    run_cmd(32'h500, 32'h600, 0, 0, drel);
    check("t4_done_cycle", drel, 1); check("t4_result", result, 0);
    check("t4_no_reads", ack_cnt, 0);

    // carry out of bit 31
    va[0] = 32'hB505; va[1] = 32'hB505; vb[0] = 0; vb[1] = 0;
    run_cmd(32'h800, 32'h900, 2, 0, drel);
    check("t5_done_cycle", drel, 7); check("t5_result", result, 32'h2432);
    check("t5_ovf", ovf, 1);

    // abort on the second B fetch, with its ack in the same cycle; start while busy
    va[0] = 1; va[1] = 2; va[2] = 3; vb[0] = 4; vb[1] = 5; vb[2] = 6;
    prep_cmd(32'h100, 32'h200, 3, 0);
    exp_result = 17; exp_ovf = 1'b0; exp_done_rel = 1000000;
    launch(32'h100, 32'h200, 3);
    aborted = 0;
    for (int k = 0; k < 40 && !aborted; k++) begin
      start = (k == 1);
      if (k == 1) len = 8'd1;
      if (rd_req && rd_ack && ack_cnt == 4) begin
        abort = 1'b1; aborted = 1;
      end
      if (!aborted) @(negedge clk);
    end
    check("abort_reached", aborted, 1);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("t6_idle_busy", busy, 0); check("t6_no_done", done, 0);
    check("t6_rd_req", rd_req, 0);  check("t6_partial", result, 17);
    active = 0;

    // clean restart clears the partial total
    va[0] = 1; va[1] = 1; vb[0] = 1; vb[1] = 1;
    run_cmd(32'h300, 32'h400, 2, -1, drel);
    check("t7_result", result, 4); check("t7_ovf", ovf, 0);

    // randomized commands, including address wrap
    for (int r = 0; r < 40; r++) begin
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 8));
      ba = $urandom & 32'hFFFF_FFFC;
      bb = $urandom & 32'hFFFF_FFFC;
      if (r == 0) begin ba = 32'hFFFF_FFF8; bb = 32'h10; n = 4; end
      for (int i = 0; i < n; i++) begin
        va[i] = (r % 2 == 1) ? $urandom : 32'($urandom_range(0, 32'hFFFF));
        vb[i] = (r % 2 == 1) ? $urandom : 32'($urandom_range(0, 32'hFFFF));
      end
      run_cmd(ba, bb, n, -1, drel);
    end

    // async reset mid-command
    for (int i = 0; i < 10; i++) begin va[i] = i + 1; vb[i] = i + 2; end
    prep_cmd(32'h1000, 32'h2000, 10, 0);
    launch(32'h1000, 32'h2000, 10);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);     check("arst_result", result, 0);
    check("arst_rd_req", rd_req, 0); check("arst_rd_addr", rd_addr, 0);
    check("arst_op1", alu_op1, 0);   check("arst_op2", alu_op2, 0);
    check("arst_ovf", ovf, 0);       check("arst_vec_en", alu_vec_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    va[0] = 3; vb[0] = 4;
    run_cmd(32'h0, 32'h40, 1, 1, drel);
    check("t9_result", result, 25); check("t9_done_cycle", drel, 6);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
